crf_tree_stage: RTL and testbench

//   One decision-tree stage of the CRF/NLP accelerator.
//   - Delays each sample and its node index through a register pipeline that matches the SRAM read latency.
//   - Compares one selected feature against the node threshold read from SRAM and emits the child node index.
//   - A leaf path rescales one selected feature as feature*mult + offset.

---
 rtl/crf_tree_stage.sv | 121 ++++++++++++
 tb/tb_crf_tree_stage.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/crf_tree_stage.sv
// crf_tree_stage: one CRF decision-tree stage -- sample/node delay line matched to SRAM latency,
// threshold compare producing the child index, and a one-edge leaf rescale. Macro CRF_LEAF_SAT_EN saturates the leaf result.

module crf_leaf_lane #(
    parameter int FEAT_W = 32,
    parameter int LANE   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [FEAT_W-1:0] featIn,
    input  logic [1:0]        featSel,
    input  logic [FEAT_W-1:0] multFactor,
    input  logic [FEAT_W-1:0] offsetFactor,
    output logic [FEAT_W-1:0] featOut
);
    logic              hit;
    logic [FEAT_W-1:0] rescaled;

    assign hit = (featSel == 2'(LANE));

`ifdef CRF_LEAF_SAT_EN
    localparam int PROD_W = 2 * FEAT_W;
    logic [PROD_W-1:0] scaled;

    always_comb begin
        scaled   = PROD_W'(featIn) * PROD_W'(multFactor) + PROD_W'(offsetFactor);
        rescaled = (|scaled[PROD_W-1:FEAT_W]) ? '1 : scaled[FEAT_W-1:0];
    end
`else
    // The low half of the wide product-plus-offset equals this truncated result.
    always_comb begin
        rescaled = featIn * multFactor + offsetFactor;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) featOut <= '0;
        else       featOut <= hit ? rescaled : featIn;
    end
endmodule

module crf_tree_stage #(
    parameter int PIPE_DEPTH = 4,
    parameter int NODE_W     = 1,
    parameter int FEAT_W     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*FEAT_W-1:0]   sample_in,
    input  logic [NODE_W-1:0]     node_index_in,
    input  logic [31:0]           sram_data,
    input  logic [FEAT_W-1:0]     mult_factor,
    input  logic [FEAT_W-1:0]     offset_factor,
    input  logic [1:0]            feature_index,
    output logic [4*FEAT_W-1:0]   sample_pipe,
    output logic [NODE_W-1:0]     node_index_pipe,
    output logic [NODE_W:0]       next_node_index,
    output logic [4*FEAT_W-1:0]   leaf_sample_out
);
    localparam int NUM_FEAT = 4;
    localparam int SAMPLE_W = NUM_FEAT * FEAT_W;
    localparam int CMP_W    = (FEAT_W > 24) ? FEAT_W : 24;

    logic [PIPE_DEPTH-1:0][SAMPLE_W-1:0]  sampleReg;
    logic [PIPE_DEPTH-1:0][NODE_W-1:0]    nodeReg;
    logic [NUM_FEAT-1:0][FEAT_W-1:0]      featPipe;
    logic [NUM_FEAT-1:0][FEAT_W-1:0]      featIn;
    logic [NUM_FEAT-1:0][FEAT_W-1:0]      leafFeat;
    logic [FEAT_W-1:0]                    nodeFeat;
    logic [23:0]                          threshold;
    logic                                 lt;
    logic                                 unusedNodeBits;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sampleReg <= '0;
            nodeReg   <= '0;
        end else begin
            sampleReg[0] <= sample_in;
            nodeReg[0]   <= node_index_in;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                sampleReg[i] <= sampleReg[i-1];
                nodeReg[i]   <= nodeReg[i-1];
            end
        end
    end

    assign sample_pipe     = sampleReg[PIPE_DEPTH-1];
    assign node_index_pipe = nodeReg[PIPE_DEPTH-1];

    // sram_data arrives aligned with the delayed sample, so the compare sees both together.
    assign featPipe       = sample_pipe;
    assign threshold      = sram_data[31:8];
    assign nodeFeat       = featPipe[sram_data[1:0]];
    assign lt             = CMP_W'(nodeFeat) < CMP_W'(threshold);
    assign unusedNodeBits = ^sram_data[7:2];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) next_node_index <= '0;
        else       next_node_index <= {node_index_pipe, lt};
    end

    assign featIn = sample_in;

    for (genvar g = 0; g < NUM_FEAT; g++) begin : gLane
        crf_leaf_lane #(
            .FEAT_W (FEAT_W),
            .LANE   (g)
        ) uLane (
            .clk          (clk),
            .reset        (reset),
            .featIn       (featIn[g]),
            .featSel      (feature_index),
            .multFactor   (mult_factor),
            .offsetFactor (offset_factor),
            .featOut      (leafFeat[g])
        );
    end

    assign leaf_sample_out = leafFeat;
endmodule

// File: tb/tb_crf_tree_stage.sv
// tb_crf_tree_stage: randomized and directed checks of crf_tree_stage against a queue-based reference model.

module tb_crf_tree_stage;
    localparam int PD = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] sample_in;
    logic         node_index_in;
    logic [31:0]  sram_data;
    logic [31:0]  mult_factor;
    logic [31:0]  offset_factor;
    logic [1:0]   feature_index;
    logic [127:0] sample_pipe;
    logic         node_index_pipe;
    logic [1:0]   next_node_index;
    logic [127:0] leaf_sample_out;

    crf_tree_stage #(.PIPE_DEPTH(PD), .NODE_W(1), .FEAT_W(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .sample_in       (sample_in),
        .node_index_in   (node_index_in),
        .sram_data       (sram_data),
        .mult_factor     (mult_factor),
        .offset_factor   (offset_factor),
        .feature_index   (feature_index),
        .sample_pipe     (sample_pipe),
        .node_index_pipe (node_index_pipe),
        .next_node_index (next_node_index),
        .leaf_sample_out (leaf_sample_out)
    );

    always #5 clk = ~clk;

    int           nCmp = 0;
    int           nBad = 0;
    logic [127:0] sampQ[$];
    logic         nodeQ[$];
    logic [1:0]   expNext;
    logic [127:0] expLeaf;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] expPipeSample();
        return (sampQ.size() == PD) ? sampQ[0] : 128'h0;
    endfunction

    function automatic logic expPipeNode();
        return (nodeQ.size() == PD) ? nodeQ[0] : 1'b0;
    endfunction

    function automatic logic [127:0] leafModel(input logic [127:0] s, input logic [1:0] fi,
                                               input logic [31:0] m, input logic [31:0] o);
        logic [127:0] res;
        logic [63:0]  r;
        logic [31:0]  v;
        int           idx;
        idx = int'(fi);
        r   = 64'(s[idx*32 +: 32]) * 64'(m) + 64'(o);
        v   = r[31:0];
`ifdef CRF_LEAF_SAT_EN
        if (r > 64'h0000_0000_FFFF_FFFF) v = 32'hFFFF_FFFF;
`endif
        res = s;
        res[idx*32 +: 32] = v;
        return res;
    endfunction

    // Advance one edge: update the reference from the inputs seen at the edge, then compare at the falling edge.
    task automatic cycle();
        logic [127:0] cur;
        logic [31:0]  f;
        int           idx;
        @(posedge clk);
        if (reset) begin
            sampQ.delete();
            nodeQ.delete();
            expNext = '0;
            expLeaf = '0;
        end else begin
            cur     = expPipeSample();
            idx     = int'(sram_data[1:0]);
            f       = cur[idx*32 +: 32];
            expNext = {expPipeNode(), (f < {8'h0, sram_data[31:8]})};
            expLeaf = leafModel(sample_in, feature_index, mult_factor, offset_factor);
            sampQ.push_back(sample_in);
            nodeQ.push_back(node_index_in);
            if (sampQ.size() > PD) begin
                void'(sampQ.pop_front());
                void'(nodeQ.pop_front());
            end
        end
        @(negedge clk);
        chk("sample_pipe", sample_pipe, expPipeSample());
        chk("node_index_pipe", 128'(node_index_pipe), 128'(expPipeNode()));
        chk("next_node_index", 128'(next_node_index), 128'(expNext));
        chk("leaf_sample_out", leaf_sample_out, expLeaf);
    endtask

    task automatic idleInputs();
        sample_in = '0; node_index_in = 1'b0; sram_data = '0;
        mult_factor = '0; offset_factor = '0; feature_index = '0;
    endtask

    task automatic nodeTest(input string name, input logic [31:0] feat0, input logic node,
                            input logic [31:0] sram, input logic [1:0] exp);
        sample_in = {96'h0, feat0}; node_index_in = node; sram_data = sram;
        cycle();
        sample_in = '0; node_index_in = 1'b0;
        repeat (PD) cycle();
        chk(name, 128'(next_node_index), 128'(exp));
    endtask

    task automatic leafTest(input string name, input logic [127:0] s, input logic [1:0] fi,
                            input logic [31:0] m, input logic [31:0] o, input logic [127:0] exp);
        sample_in = s; feature_index = fi; mult_factor = m; offset_factor = o;
        cycle();
        chk(name, leaf_sample_out, exp);
    endtask

    logic [127:0] seq[5];

    initial begin
        idleInputs();
        reset = 1'b1;
        #1;
        chk("reset_sample_pipe", sample_pipe, 128'h0);
        chk("reset_next_node", 128'(next_node_index), 128'h0);
        cycle();
        cycle();
        chk("reset_leaf", leaf_sample_out, 128'h0);
        reset = 1'b0;

        nodeTest("node_ge", 32'd8, 1'b0, 32'h400, 2'b00);
        nodeTest("node_lt", 32'd4, 1'b0, 32'h900, 2'b01);
        nodeTest("node_eq", 32'd8, 1'b1, 32'h800, 2'b10);
        nodeTest("node_lt1", 32'd4, 1'b1, 32'h800, 2'b11);

        leafTest("leaf_mul", 128'h8, 2'd0, 32'd8, 32'd0, 128'h40);
        leafTest("leaf_off", 128'h8, 2'd0, 32'd8, 32'd5, 128'h45);
        leafTest("leaf_feat2", {32'hDEADBEEF, 32'd3, 32'h12345678, 32'h9ABCDEF0}, 2'd2, 32'd2, 32'd1,
                 {32'hDEADBEEF, 32'd7, 32'h12345678, 32'h9ABCDEF0});
`ifdef CRF_LEAF_SAT_EN
        leafTest("leaf_ovf", 128'hFFFF_FFFF, 2'd0, 32'd2, 32'd0, 128'hFFFF_FFFF);
`else
        leafTest("leaf_ovf", 128'hFFFF_FFFF, 2'd0, 32'd2, 32'd0, 128'hFFFF_FFFE);
`endif
        idleInputs();

        for (int k = 0; k < 5; k++) seq[k] = {$urandom, $urandom, $urandom, $urandom};
        for (int k = 0; k < 5 + PD; k++) begin
            sample_in = (k < 5) ? seq[k] : 128'h0;
            cycle();
            if (k >= PD - 1 && k - (PD - 1) < 5)
                chk("pipe_order", sample_pipe, seq[k - (PD - 1)]);
        end

        // Fill everything with non-zero data, then assert reset between edges.
        sample_in = {4{32'h0000_0005}}; node_index_in = 1'b1; sram_data = 32'hFFFF_FF00;
        mult_factor = 32'd3; offset_factor = 32'd1;
        repeat (PD + 1) cycle();
        reset = 1'b1;
        #1;
        chk("async_sample_pipe", sample_pipe, 128'h0);
        chk("async_node_pipe", 128'(node_index_pipe), 128'h0);
        chk("async_next_node", 128'(next_node_index), 128'h0);
        chk("async_leaf", leaf_sample_out, 128'h0);
        cycle();
        reset = 1'b0;
        repeat (PD + 1) cycle();

        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < 4; k++)
                sample_in[k*32 +: 32] = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 15)) : $urandom;
            node_index_in = 1'($urandom_range(0, 1));
            sram_data     = ($urandom_range(0, 1) == 1) ? {24'($urandom_range(0, 15)), 8'($urandom)} : $urandom;
            mult_factor   = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 9)) : $urandom;
            offset_factor = $urandom;
            feature_index = 2'($urandom_range(0, 3));
            reset         = ($urandom_range(0, 63) == 0);
            cycle();
        end
        reset = 1'b0;
        repeat (PD + 1) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end
endmodule
